word_stream_arbiter: RTL and testbench

- Shares the single 32-bit write port of the width adapter buffer between NUM_REQ word producers (e.g. per-component Huffman/bitpacker lanes).
- Grants one requester at a time for a whole packet, delimited by a last flag, using round-robin order.
- The adapter has no backpressure, so this block keeps a drain-rate occupancy model and throttles issue so the adapter FIFO cannot overflow.

---
 rtl/word_arb_pkg.sv | 20 ++
 rtl/word_stream_arbiter_rr_pick.sv | 33 +++
 rtl/word_stream_arbiter.sv | 148 ++++++++++++++
 tb/tb_word_stream_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_arb_pkg.sv
// rtl/word_arb_pkg.sv - shared types and defaults for the word stream arbiter
// Contents: arbiter state enum, default parameter values, occupancy width helper.
package word_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_RATIO      = 4;
    localparam int DEF_BUF_DEPTH  = 256;
    localparam int DEF_MARGIN     = 4;

    // Occupancy must be able to hold BUF_DEPTH itself, hence the extra bit.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/word_stream_arbiter_rr_pick.sv
// rtl/word_stream_arbiter_rr_pick.sv - combinational cyclic first-one finder
// Ports:
//   req   in  N   request vector
//   start in  IW  index where the cyclic search begins
//   index out IW  first set request at or after start (0 when none)
//   found out 1   any request set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] index,
    output logic          found
);

    logic [IW-1:0] pos;

    // Walk offsets 0..N-1 from start; the first hit wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(start) + k) % N);
            if (!found && req[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/word_stream_arbiter.sv
// rtl/word_stream_arbiter.sv - packet round-robin arbiter with adapter occupancy throttle
// Optional build macro: WORD_ARB_FIXED_PRIORITY_EN (lowest-index requester always wins).
// Ports:
//   clock      in  1                    system clock
//   nreset     in  1                    synchronous active-low reset
//   req_valid  in  NUM_REQ              per-requester word valid
//   req_data   in  NUM_REQ*WORD_WIDTH   requester i word in [i*WORD_WIDTH +: WORD_WIDTH]
//   req_last   in  NUM_REQ              final word of requester i's packet
//   req_ready  out NUM_REQ              one-hot or zero transfer enable
//   out_valid  out 1                    adapter data_in_valid
//   out_data   out WORD_WIDTH           adapter data_in
//   grant_id   out clog2(NUM_REQ)       current or last granted requester
//   busy       out 1                    high in BURST
//   occupancy  out clog2(BUF_DEPTH)+1   modelled adapter fill level in words
module word_stream_arbiter
    import word_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int RATIO      = DEF_RATIO,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int MARGIN     = DEF_MARGIN,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int OCC_W     = occ_width(BUF_DEPTH)
) (
    input  logic                          clock,
    input  logic                          nreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [WORD_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [OCC_W-1:0]              occupancy
);

    localparam int DRAIN_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    arb_state_t             state;
    logic [ID_W-1:0]        rr_ptr;
    logic [DRAIN_W-1:0]     drain_cnt;

    logic [ID_W-1:0]        pick_index;
    logic                   pick_found;
    logic [WORD_WIDTH-1:0]  sel_data;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   credit_ok;
    logic                   handshake;
    logic                   occ_inc;
    logic                   occ_dec;
    logic [ID_W-1:0]        next_ptr;

    // In fixed-priority builds rr_ptr is pinned at 0, so the search always starts at requester 0.
    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .index (pick_index),
        .found (pick_found)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_data  = req_data[i*WORD_WIDTH +: WORD_WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // Headroom check uses registered occupancy only, so ready drops in the cycle the limit is reached.
    assign credit_ok = occupancy < OCC_W'(BUF_DEPTH - MARGIN);

    // Ready is forced low while reset is asserted, even before the reset edge lands.
    always_comb begin
        req_ready = '0;
        if (nreset && (state == BURST) && credit_ok) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = nreset && (state == BURST) && credit_ok && sel_valid;
    assign occ_inc   = handshake;
    assign occ_dec   = (occupancy != '0) && (drain_cnt == DRAIN_W'(RATIO - 1));
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy      = (state == BURST);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            occupancy <= '0;
            drain_cnt <= '0;
        end else begin
            out_valid <= handshake;
            if (handshake) begin
                out_data <= sel_data;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_index;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (handshake && sel_last) begin
`ifdef WORD_ARB_FIXED_PRIORITY_EN
                        rr_ptr <= '0;
`else
                        rr_ptr <= next_ptr;
`endif
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Saturating occupancy; a coincident increment and decrement cancel.
            if (occ_inc && !occ_dec && (occupancy != OCC_W'(BUF_DEPTH))) begin
                occupancy <= occupancy + 1'b1;
            end else if (occ_dec && !occ_inc) begin
                occupancy <= occupancy - 1'b1;
            end

            // The drain phase only advances while the model holds words.
            if ((occupancy == '0) || (drain_cnt == DRAIN_W'(RATIO - 1))) begin
                drain_cnt <= '0;
            end else begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_stream_arbiter.sv
// tb/tb_word_stream_arbiter.sv - self-checking bench for word_stream_arbiter
module tb_word_stream_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int OCC_W = 9;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     lane_data [N];
    logic [N*W-1:0]   req_data;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic [OCC_W-1:0] occupancy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] sb_exp;
    int           ov_cyc [$];

    typedef struct {
        logic [N-1:0] mask;
        int           exp_rr;
        int           exp_fixed;
    } vec_t;
    vec_t tbl [12];

    word_stream_arbiter dut (
        .clock     (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = lane_data[i];
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on output, push the word the bench is presenting whenever a transfer is enabled.
    always begin
        @(posedge clk);
        #3;
        if (mon_en) begin
            if (out_valid) begin
                ov_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", longint'(out_data), -1);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("sb_data", longint'(out_data), longint'(sb_exp));
                end
            end
            if ($countones(req_ready) > 1)
                check("ready_onehot", longint'($countones(req_ready)), 1);
            for (int i = 0; i < N; i++)
                if (req_ready[i] && req_valid[i]) sb_q.push_back(lane_data[i]);
        end
    end

    task automatic do_reset();
        nreset    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    // Called at posedge+1; presents nw words on lane idx, advancing after each accepted word.
    task automatic send_pkt(input int idx, input int nw, input logic [W-1:0] base, input int budget);
        int   sent;
        logic hs;
        sent           = 0;
        lane_data[idx] = base;
        req_last[idx]  = (nw == 1);
        req_valid[idx] = 1'b1;
        for (int k = 0; k < budget && sent < nw; k++) begin
            #1;
            hs = req_ready[idx];
            tick();
            if (hs) begin
                sent++;
                lane_data[idx] = base + W'(sent);
                req_last[idx]  = (sent == nw - 1);
                if (sent == nw) begin
                    req_valid[idx] = 1'b0;
                    req_last[idx]  = 1'b0;
                end
            end
        end
        check("send_complete", longint'(sent), longint'(nw));
    endtask

    initial begin
        int   found, idx, exp, last_c, v0, zero_c, hit, nacc;
        logic hs;

        for (int i = 0; i < N; i++) lane_data[i] = '0;

        tbl[0]  = '{4'b1111, 0, 0};
        tbl[1]  = '{4'b1111, 1, 0};
        tbl[2]  = '{4'b1111, 2, 0};
        tbl[3]  = '{4'b1111, 3, 0};
        tbl[4]  = '{4'b1111, 0, 0};
        tbl[5]  = '{4'b0101, 2, 0};
        tbl[6]  = '{4'b0101, 0, 0};
        tbl[7]  = '{4'b1000, 3, 3};
        tbl[8]  = '{4'b0011, 0, 0};
        tbl[9]  = '{4'b0010, 1, 1};
        tbl[10] = '{4'b0110, 2, 1};
        tbl[11] = '{4'b0001, 0, 0};

        // Reset state
        do_reset();
        mon_en = 1'b1;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_occupancy", longint'(occupancy), 0);
        check("rst_grant_id", longint'(grant_id), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ready", longint'(req_ready), 0);
        tick();

        // Single packet from requester 2
        ov_cyc.delete();
        v0 = cyc;
        send_pkt(2, 3, 32'hA0, 20);
        tick();
        tick();
        check("single_ov_count", longint'(ov_cyc.size()), 3);
        if (ov_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++)
                check("single_ov_cycle", longint'(ov_cyc[i]), longint'(v0 + 2 + i));
        end
        check("single_grant", longint'(grant_id), 2);

        // Arbitration table: one-word packets, expected grant per record
        do_reset();
        last_c = 0;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) lane_data[i] = W'(32'h100 * r + i);
            req_last  = '1;
            req_valid = tbl[r].mask;
            found = 0;
            idx   = -1;
            for (int w = 0; w < 4 && found == 0; w++) begin
                tick();
                #1;
                if (req_ready != '0) begin
                    found = 1;
                    for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                end
            end
`ifdef WORD_ARB_FIXED_PRIORITY_EN
            exp = tbl[r].exp_fixed;
`else
            exp = tbl[r].exp_rr;
`endif
            check("arb_grant", longint'(idx), longint'(exp));
            if (r > 0) check("arb_packet_cycles", longint'(cyc - last_c), 2);
            last_c = cyc;
            tick();
            req_valid = '0;
            req_last  = '0;
        end
        tick();

        // Stall: granted requester 0 drops valid mid-packet while requester 1 waits
        do_reset();
        lane_data[0] = 32'hD0;
        lane_data[1] = 32'hE0;
        req_last     = 4'b0010;
        req_valid    = 4'b0011;
        tick();
        #1;
        check("stall_first_grant", longint'(grant_id), 0);
        tick();
        lane_data[0] = 32'hD1;
        tick();
        req_valid[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("stall_hold_grant", longint'(grant_id), 0);
            check("stall_req1_ready", longint'(req_ready[1]), 0);
            check("stall_out_valid", longint'(out_valid), 0);
            check("stall_busy", longint'(busy), 1);
        end
        lane_data[0] = 32'hD2;
        req_last[0]  = 1'b1;
        req_valid[0] = 1'b1;
        tick();
        tick();
        #1;
        check("stall_next_grant", longint'(grant_id), 1);
        check("stall_next_ready", longint'(req_ready), 2);
        tick();
        req_valid = '0;
        req_last  = '0;
        tick();

        // Drain: 10 back-to-back words, then empty out at one word per 4 cycles
        do_reset();
        ov_cyc.delete();
        send_pkt(0, 10, 32'h5000, 30);
        check("drain_occ_after_burst", longint'(occupancy), 8);
        zero_c = -1;
        for (int k = 0; k < 80 && zero_c < 0; k++) begin
            #1;
            if (occupancy == 0) zero_c = cyc;
            else tick();
        end
        if (ov_cyc.size() > 0) check("drain_zero_cycle", longint'(zero_c - ov_cyc[0]), 40);
        else check("drain_no_output", 0, 1);
        tick();
        tick();
        #1;
        check("drain_stays_zero", longint'(occupancy), 0);
        tick();

        // Throttle: requester 0 streams one long packet
        do_reset();
        lane_data[0] = 32'h7000_0000;
        req_last     = '0;
        req_valid    = 4'b0001;
        hit = 0;
        for (int k = 0; k < 600 && hit == 0; k++) begin
            #1;
            if (occupancy == 252) begin
                hit = 1;
                check("throttle_ready_drop", longint'(req_ready[0]), 0);
            end else begin
                hs = req_ready[0];
                tick();
                if (hs) lane_data[0] = lane_data[0] + 1;
            end
        end
        check("throttle_reached_limit", longint'(hit), 1);
        tick();
        nacc = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            check("throttle_occ_range", longint'(occupancy >= 251 && occupancy <= 252), 1);
            if (occupancy == 251) check("throttle_ready_back", longint'(req_ready[0]), 1);
            if (occupancy == 252) check("throttle_ready_low", longint'(req_ready[0]), 0);
            hs = req_ready[0];
            if (hs) nacc++;
            tick();
            if (hs) lane_data[0] = lane_data[0] + 1;
        end
        check("throttle_accept_rate", longint'(nacc), 10);
        req_valid = '0;
        tick();

        // Reset in the middle of a burst
        do_reset();
        send_pkt(1, 1, 32'hB0, 8);
        lane_data[2] = 32'hC0;
        req_last     = '0;
        req_valid[2] = 1'b1;
        tick();
        tick();
        nreset = 1'b0;
        #1;
        check("mid_rst_ready_gated", longint'(req_ready), 0);
        tick();
        nreset = 1'b1;
        for (int i = 0; i < N; i++) lane_data[i] = W'(32'hF0 + i);
        req_last  = '1;
        req_valid = '1;
        #1;
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_occupancy", longint'(occupancy), 0);
        check("mid_rst_ready", longint'(req_ready), 0);
        tick();
        #1;
        check("mid_rst_regrant", longint'(grant_id), 0);
        check("mid_rst_regrant_ready", longint'(req_ready), 1);
        tick();
        req_valid = '0;
        req_last  = '0;
        tick();
        tick();
        #1;
        check("sb_drained", longint'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
